// File: rtl/combo_scorer_pkg.sv
// Shared types and helpers for the hit-judging / combo scoring stage.
// Holds lane vector, combo and multiplier types plus the multiplier/popcount helpers.
package rb_score_pkg;

    localparam int unsigned NUM_LANES   = 4;
    localparam int unsigned NUM_PLAYERS = 2;
    localparam int unsigned BONUS_STEP  = 50;

    typedef logic [NUM_LANES-1:0] lane_vec_t;
    typedef logic [6:0]           combo_t;
    typedef logic [2:0]           mult_t;

    // Multiplier is a pure function of the registered combo: 1 + combo/step, capped.
    function automatic mult_t mult_of(input combo_t combo, input int unsigned step,
                                      input int unsigned max_mult);
        int unsigned m;
        m = 1 + 32'(combo) / step;
        if (m > max_mult) m = max_mult;
        return mult_t'(m);
    endfunction

    function automatic logic [2:0] hit_count(input lane_vec_t v);
        logic [2:0] n;
        n = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) n = n + 3'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/combo_scorer_if.sv
// Key/window inputs and score-counter outputs of combo_scorer, grouped as one bus.
// master = stimulus side (game/keyboard), slave = the scorer itself.
interface combo_scorer_if;
    import rb_score_pkg::*;

    logic       active;
    logic [7:0] keyTrack;
    lane_vec_t  hit_win;
    logic [7:0] inc1;
    logic [7:0] inc2;
    logic       ld_sc1;
    logic       ld_sc2;
    combo_t     combo1;
    combo_t     combo2;
    mult_t      mult1;
    mult_t      mult2;

    modport master (
        output active, keyTrack, hit_win,
        input  inc1, inc2, ld_sc1, ld_sc2, combo1, combo2, mult1, mult2
    );

    modport slave (
        input  active, keyTrack, hit_win,
        output inc1, inc2, ld_sc1, ld_sc2, combo1, combo2, mult1, mult2
    );

endinterface

// File: rtl/combo_scorer_player_judge.sv
// One player's press-edge detection, lane locks, combo tracking and score pulses.
// Optional milestone bonus is compiled in with `define COMBO_BONUS_EN.
module player_judge
    import rb_score_pkg::*;
#(
    parameter int unsigned BASE_POINTS = 1,
    parameter int unsigned COMBO_STEP  = 10,
    parameter int unsigned MAX_MULT    = 4,
    parameter int unsigned COMBO_MAX   = 99,
    parameter int unsigned BONUS_PTS   = 50
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       active_i,
    input  lane_vec_t  key_i,
    input  lane_vec_t  win_i,
    input  lane_vec_t  win_close_i,
    output logic [7:0] inc_o,
    output logic       ld_o,
    output combo_t     combo_o,
    output mult_t      mult_o
);

    lane_vec_t   key_q;
    lane_vec_t   lock_q, lock_d;
    combo_t      combo_q, combo_d;
    logic [7:0]  inc_q, inc_d;
    logic        ld_q, ld_d;

    lane_vec_t   press, hit_vec, ghost_vec, pass_vec;
    logic [2:0]  hits;
    logic        miss;
    mult_t       mult_cur;
    logic [7:0]  sum;
    int unsigned pts;

    always_comb begin
        press     = key_i & ~key_q;
        mult_cur  = mult_of(combo_q, COMBO_STEP, MAX_MULT);
        hit_vec   = active_i ? (press & win_i & ~lock_q) : '0;
        ghost_vec = active_i ? (press & (~win_i | lock_q)) : '0;
        pass_vec  = active_i ? (win_close_i & ~lock_q) : '0;
        // Locks keep tracking while inactive so re-enabling sees a clean state.
        lock_d    = (lock_q | hit_vec) & ~win_close_i;
        hits      = hit_count(hit_vec);
        miss      = |(ghost_vec | pass_vec);

        sum = 8'(combo_q) + 8'(hits);
        if (!active_i || miss)        combo_d = '0;
        else if (32'(sum) > COMBO_MAX) combo_d = combo_t'(COMBO_MAX);
        else                          combo_d = combo_t'(sum);

        pts  = BASE_POINTS * 32'(mult_cur) * 32'(hits);
        ld_d = (hits != '0);
`ifdef COMBO_BONUS_EN
        if ((32'(combo_d) / BONUS_STEP) > (32'(combo_q) / BONUS_STEP)) begin
            pts  = pts + BONUS_PTS;
            ld_d = 1'b1;
        end
`endif
        inc_d = 8'(pts);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            key_q   <= '0;
            lock_q  <= '0;
            combo_q <= '0;
            inc_q   <= '0;
            ld_q    <= 1'b0;
        end else begin
            key_q   <= key_i;
            lock_q  <= lock_d;
            combo_q <= combo_d;
            inc_q   <= inc_d;
            ld_q    <= ld_d;
        end
    end

    assign inc_o   = inc_q;
    assign ld_o    = ld_q;
    assign combo_o = combo_q;
    assign mult_o  = mult_of(combo_q, COMBO_STEP, MAX_MULT);

endmodule

// File: rtl/combo_scorer.sv
// Two-player hit judge: shared strike-window edge register plus one player_judge per player.
// Optional macro COMBO_BONUS_EN adds a milestone bonus every 50 combo.
module combo_scorer
    import rb_score_pkg::*;
#(
    parameter int unsigned BASE_POINTS = 1,
    parameter int unsigned COMBO_STEP  = 10,
    parameter int unsigned MAX_MULT    = 4,
    parameter int unsigned COMBO_MAX   = 99,
    parameter int unsigned BONUS_PTS   = 50
) (
    input logic           Clk,
    input logic           Reset,
    combo_scorer_if.slave bus
);

`ifdef COMBO_BONUS_EN
    localparam int unsigned MAX_INC = BASE_POINTS * MAX_MULT * NUM_LANES + BONUS_PTS;
`else
    localparam int unsigned MAX_INC = BASE_POINTS * MAX_MULT * NUM_LANES;
`endif

    if (MAX_MULT < 1 || MAX_MULT > 7) begin : g_bad_mult
        $error("combo_scorer: MAX_MULT must be 1..7");
    end
    if (MAX_INC > 255 || BONUS_PTS > 255) begin : g_bad_inc
        $error("combo_scorer: maximum inc exceeds 8 bits");
    end
    if (COMBO_STEP == 0 || COMBO_MAX > 127) begin : g_bad_combo
        $error("combo_scorer: COMBO_STEP must be >0 and COMBO_MAX <= 127");
    end

    lane_vec_t win_q;
    lane_vec_t win_close;

    always_ff @(posedge Clk) begin
        if (Reset) win_q <= '0;
        else       win_q <= bus.hit_win;
    end

    assign win_close = win_q & ~bus.hit_win;

    player_judge #(
        .BASE_POINTS (BASE_POINTS),
        .COMBO_STEP  (COMBO_STEP),
        .MAX_MULT    (MAX_MULT),
        .COMBO_MAX   (COMBO_MAX),
        .BONUS_PTS   (BONUS_PTS)
    ) u_p1 (
        .clk_i       (Clk),
        .rst_i       (Reset),
        .active_i    (bus.active),
        .key_i       (bus.keyTrack[3:0]),
        .win_i       (bus.hit_win),
        .win_close_i (win_close),
        .inc_o       (bus.inc1),
        .ld_o        (bus.ld_sc1),
        .combo_o     (bus.combo1),
        .mult_o      (bus.mult1)
    );

    player_judge #(
        .BASE_POINTS (BASE_POINTS),
        .COMBO_STEP  (COMBO_STEP),
        .MAX_MULT    (MAX_MULT),
        .COMBO_MAX   (COMBO_MAX),
        .BONUS_PTS   (BONUS_PTS)
    ) u_p2 (
        .clk_i       (Clk),
        .rst_i       (Reset),
        .active_i    (bus.active),
        .key_i       (bus.keyTrack[7:4]),
        .win_i       (bus.hit_win),
        .win_close_i (win_close),
        .inc_o       (bus.inc2),
        .ld_o        (bus.ld_sc2),
        .combo_o     (bus.combo2),
        .mult_o      (bus.mult2)
    );

endmodule
